// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: drives one external 1-bit ALU slice LSB-first
// over WIDTH cycles, carrying the chain in a flop and assembling the result.
module alu_serial_ctrl #(
  parameter int WIDTH = 32,
  parameter int CW    = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             carry_out_o,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_cin_o,
  output logic             slice_less_o,
  output logic [2:0]       slice_op_o,
  input  logic             slice_r_i,
  input  logic             slice_cout_i,
  input  logic             slice_v_i,
  input  logic             slice_set_i
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] final_w;
  logic             accept_w;
  logic             last_w;

  // Bits accumulate in acc_q so the visible result only moves at end of RUN.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    accept_w = 1'b0;
    last_w   = (idx_q == CW'(WIDTH - 1));
    final_w  = acc_q;
    final_w[idx_q] = slice_r_i;
    // Set-less-than: upper bits are already 0 since the slice's less input is 0.
    if (op_q[1:0] == 2'b11) final_w[0] = slice_set_i;

    case (state_q)
      IDLE: accept_w = start_i;
      RUN: begin
        acc_d   = acc_q;
        acc_d[idx_q] = slice_r_i;
        carry_d = slice_cout_i;
        idx_d   = idx_q + 1'b1;
        if (last_w) begin
          idx_d    = '0;
          result_d = final_w;
          zero_d   = (final_w == '0);
          ovf_d    = slice_v_i;
          cout_d   = slice_cout_i;
          state_d  = DONE;
        end
      end
      DONE: begin
        accept_w = start_i;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept_w) begin
      a_d     = a_i;
      b_d     = b_i;
      op_d    = op_i;
      idx_d   = '0;
      carry_d = 1'b0;
      state_d = RUN;
    end
  end

  always_comb begin
    ready_o      = (state_q == IDLE) || (state_q == DONE);
    busy_o       = (state_q == RUN);
    done_o       = (state_q == DONE);
    result_o     = result_q;
    zero_o       = zero_q;
    overflow_o   = ovf_q;
    carry_out_o  = cout_q;
    slice_op_o   = op_q;
    slice_less_o = 1'b0;
    slice_a_o    = busy_o ? a_q[idx_q] : 1'b0;
    slice_b_o    = busy_o ? b_q[idx_q] : 1'b0;
    slice_cin_o  = busy_o ? ((idx_q == '0) ? op_q[2] : carry_q) : 1'b0;
  end

endmodule
